btb_pc: RTL and testbench
=========================

# btb_pc

Fetch-stage program counter with a direct-mapped branch target buffer (BTB) and 2-bit saturating predictors. Each cycle it presents the fetch PC to instruction memory. It predicts the next PC from the BTB, qualified by a predecode of the fetched instruction. It redirects on misprediction reports from the decode stage, where branches resolve.

## Interface
Parameters:
- BTB_ENTRIES, 16: number of BTB entries; power of two, ≥2. Index = PC[IDX+1:2], where IDX = log2(BTB_ENTRIES). Tag = PC[31:IDX+2].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- PC_enable  in  1  advance the PC; 0 = stall, hold PC and freeze the BTB.
- takeBranch  in  1  the branch/jump in decode resolved taken.
- PC_plus_4  in  32  current PC + 4, computed externally.
- instruction_IFID_in  in  32  instruction fetched at the current PC, used for predecode.
- branch_PC  in  32  resolved taken target of the decode-stage branch.
- incorrect_b_prediction  in  1  the decode-stage branch was mispredicted.
- PC_IFID_IDEX  in  32  PC of the decode-stage branch.
- PC_plus4_IFID_out  in  32  PC + 4 of the decode-stage branch (fall-through).
- PC_IFID_in  out  32  current fetch PC, registered.

## Operation
- Lookup is combinational on PC_IFID_in.
  - Hit = entry valid && tag match.
  - Predict taken = hit && counter[1] && predecode says the opcode is B-type (7'b1100011) or JAL (7'b1101111).
  - JALR and all other opcodes are never predicted taken.
- Next-PC priority, highest first:
  1. incorrect_b_prediction && takeBranch → branch_PC.
  2. incorrect_b_prediction && !takeBranch → PC_plus4_IFID_out.
  3. Predict taken → BTB target.
  4. Otherwise → PC_plus_4.
- BTB update, indexed and tagged by PC_IFID_IDEX, applied only when PC_enable = 1:
  - takeBranch, entry miss: allocate. Set valid, write tag and target = branch_PC, counter = 2'b10.
  - takeBranch, entry hit: write target = branch_PC; counter increments, saturating at 2'b11.
  - incorrect_b_prediction && !takeBranch, entry hit: counter decrements, saturating at 2'b00.
  - incorrect_b_prediction && !takeBranch, entry miss: no change.
  - Neither takeBranch nor incorrect_b_prediction: no change.
- Entries are never invalidated except by reset.
- Targets are stored as full 32-bit values. No alignment checking is performed.

## Timing
- Reset, asynchronous: PC_IFID_in = 32'h0000_0000, all valid bits = 0, all counters = 2'b00. The reset effect is visible immediately and is independent of clk.
- PC_IFID_in updates on the rising edge when PC_enable = 1. The next-PC decision has one-cycle latency; a redirect takes effect on the first fetch after the edge.
- PC_enable = 0: PC is held and the BTB is not written, even if takeBranch or incorrect_b_prediction is asserted.
- The BTB write and the PC update occur on the same edge. A lookup in the same cycle sees the pre-write contents; there is no bypass.
- Reset mid-stall or mid-redirect: reset wins, and PC returns to 0.
- Deasserting rst_n: the first fetch is at PC 0.

## Configuration
- BTB_EN defined: BTB storage and prediction are instantiated as described above.
- BTB_EN undefined:
  - No BTB storage is instantiated, and prediction is always not-taken.
  - Next PC = the redirect (priorities 1 and 2), otherwise PC_plus_4.
  - PC_IFID_IDEX and instruction_IFID_in are ignored.

## Structure
- Package btb_pkg contains:
  - opcode constants OPC_BRANCH = 7'b1100011 and OPC_JAL = 7'b1101111;
  - the 2-bit counter typedef and its saturation constants;
  - the BTB entry struct {valid, tag, target, ctr}.
- Sub-module btb_table: storage, combinational lookup, and update/saturation logic. The top level holds the PC register, predecode, and the next-PC mux.

## Test plan
- Reset: assert rst_n = 0 mid-run → PC_IFID_in = 0 immediately. After release, with PC_enable = 1, PC goes 0, 4, 8 on successive edges (PC_plus_4 driven as PC+4).
- Stall: PC = 8 and PC_enable = 0 for 3 cycles, with takeBranch = 1 → PC stays 8 and the BTB is unchanged. The next lookup at the branch PC misses.
- Allocate and predict: takeBranch = 1, PC_IFID_IDEX = 0x10, branch_PC = 0x40 → entry allocated with ctr = 10. The next fetch at 0x10 with instruction_IFID_in = 0x00000063 gives next PC 0x40.
- Predecode gate: same entry, fetch at 0x10 with instruction_IFID_in = 0x00000013 (ADDI) → next PC 0x14.
- Mispredict not-taken: incorrect_b_prediction = 1, takeBranch = 0, PC_plus4_IFID_out = 0x14 → next PC 0x14 and ctr 10 → 01. The next fetch at 0x10 (B-type) is predicted not-taken, giving 0x14.
- Mispredict taken: incorrect_b_prediction = 1, takeBranch = 1, branch_PC = 0x100, with a BTB hit at the current PC predicting elsewhere → next PC 0x100. The redirect overrides the prediction.

Source files
------------

// File: rtl/btb_pkg.sv
// btb_pkg: opcode constants, 2-bit predictor counter type and BTB entry layout.
package btb_pkg;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    typedef logic [1:0] ctr_t;
    localparam ctr_t CTR_MIN  = 2'b00;
    localparam ctr_t CTR_MAX  = 2'b11;
    localparam ctr_t CTR_INIT = 2'b10;
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        ctr_t        ctr;
    } btb_entry_t;
endpackage

// File: rtl/btb_table.sv
// btb_table: direct-mapped BTB storage with combinational lookup and saturating-counter update.
module btb_table
    import btb_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] lookup_pc,
    output logic        hit,
    output logic        ctr_taken,
    output logic [31:0] target,
    input  logic        upd_en,
    input  logic        upd_taken,
    input  logic        upd_mispred,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target
);
    localparam int IDX = $clog2(ENTRIES);
    btb_entry_t mem [ENTRIES];
    logic [IDX-1:0] li, ui;
    logic [29:0] lt, ut;
    logic uhit;
    btb_entry_t e, u;
    always_comb begin
        li = lookup_pc[IDX+1:2];
        lt = 30'(lookup_pc >> (IDX + 2));
        ui = upd_pc[IDX+1:2];
        ut = 30'(upd_pc >> (IDX + 2));
        e = mem[li];
        u = mem[ui];
        hit = e.valid && e.tag == lt;
        ctr_taken = e.ctr[1];
        target = e.target;
        uhit = u.valid && u.tag == ut;
    end
    // Tags are zero-extended into a fixed 30-bit field so one struct serves every size.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
        end else if (upd_en) begin
            if (upd_taken)
                mem[ui] <= '{valid: 1'b1, tag: ut, target: upd_target,
                             ctr: !uhit ? CTR_INIT : u.ctr == CTR_MAX ? CTR_MAX : u.ctr + 2'd1};
            else if (upd_mispred && uhit)
                mem[ui].ctr <= u.ctr == CTR_MIN ? CTR_MIN : u.ctr - 2'd1;
        end
    end
endmodule

// File: rtl/btb_pc.sv
// btb_pc: fetch PC register with redirect and optional BTB prediction (enabled by BTB_EN).
module btb_pc
    import btb_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PC_enable,
    input  logic        takeBranch,
    input  logic [31:0] PC_plus_4,
    input  logic [31:0] instruction_IFID_in,
    input  logic [31:0] branch_PC,
    input  logic        incorrect_b_prediction,
    input  logic [31:0] PC_IFID_IDEX,
    input  logic [31:0] PC_plus4_IFID_out,
    output logic [31:0] PC_IFID_in
);
    logic predict;
    logic [31:0] btb_target, next_pc;
`ifdef BTB_EN
    logic btb_hit, btb_ctr_taken;
    logic [6:0] opc;
    logic unused_instr;
    btb_table #(.ENTRIES(BTB_ENTRIES)) u_btb (
        .clk(clk),
        .rst_n(rst_n),
        .lookup_pc(PC_IFID_in),
        .hit(btb_hit),
        .ctr_taken(btb_ctr_taken),
        .target(btb_target),
        .upd_en(PC_enable),
        .upd_taken(takeBranch),
        .upd_mispred(incorrect_b_prediction),
        .upd_pc(PC_IFID_IDEX),
        .upd_target(branch_PC)
    );
    always_comb begin
        opc = instruction_IFID_in[6:0];
        unused_instr = ^instruction_IFID_in[31:7];
        predict = btb_hit && btb_ctr_taken && (opc == OPC_BRANCH || opc == OPC_JAL);
    end
`else
    logic unused_btb;
    always_comb begin
        unused_btb = ^{PC_IFID_IDEX, instruction_IFID_in};
        predict = 1'b0;
        btb_target = '0;
    end
`endif
    always_comb
        next_pc = incorrect_b_prediction ? (takeBranch ? branch_PC : PC_plus4_IFID_out)
                : predict ? btb_target : PC_plus_4;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) PC_IFID_in <= '0;
        else if (PC_enable) PC_IFID_in <= next_pc;
    end
endmodule

// File: tb/tb_btb_pc.sv
// tb_btb_pc: directed scenarios for btb_pc; prediction expectations follow BTB_EN.
module tb_btb_pc;
    localparam bit BTB =
`ifdef BTB_EN
        1'b1;
`else
        1'b0;
`endif
    logic clk = 0, rst_n = 0, PC_enable, takeBranch, incorrect_b_prediction;
    logic [31:0] PC_plus_4, instruction_IFID_in, branch_PC, PC_IFID_IDEX, PC_plus4_IFID_out, PC_IFID_in;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;
    assign PC_plus_4 = PC_IFID_in + 32'd4;

    btb_pc #(.BTB_ENTRIES(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .PC_enable(PC_enable),
        .takeBranch(takeBranch),
        .PC_plus_4(PC_plus_4),
        .instruction_IFID_in(instruction_IFID_in),
        .branch_PC(branch_PC),
        .incorrect_b_prediction(incorrect_b_prediction),
        .PC_IFID_IDEX(PC_IFID_IDEX),
        .PC_plus4_IFID_out(PC_plus4_IFID_out),
        .PC_IFID_in(PC_IFID_in)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        PC_enable = 1;
        takeBranch = 0;
        incorrect_b_prediction = 0;
        branch_PC = 0;
        PC_IFID_IDEX = 0;
        PC_plus4_IFID_out = 0;
        instruction_IFID_in = 32'h13;
    endtask

    // Not-taken redirect reported for an address that misses, so no entry is touched.
    task automatic go_to(input logic [31:0] a);
        incorrect_b_prediction = 1;
        takeBranch = 0;
        PC_IFID_IDEX = 32'h80;
        PC_plus4_IFID_out = a;
        tick();
        incorrect_b_prediction = 0;
    endtask

    task automatic test_reset();
        clear_in();
        rst_n = 0;
        tick();
        tick();
        checks++; if (PC_IFID_in !== 32'h0) begin errors++; $display("FAIL reset_hold: got %h expected %h", PC_IFID_in, 32'h0); end
        @(negedge clk); rst_n = 1; #1;
        checks++; if (PC_IFID_in !== 32'h0) begin errors++; $display("FAIL first_fetch: got %h expected %h", PC_IFID_in, 32'h0); end
        tick();
        checks++; if (PC_IFID_in !== 32'h4) begin errors++; $display("FAIL seq_4: got %h expected %h", PC_IFID_in, 32'h4); end
        tick();
        checks++; if (PC_IFID_in !== 32'h8) begin errors++; $display("FAIL seq_8: got %h expected %h", PC_IFID_in, 32'h8); end
        @(negedge clk); rst_n = 0; #1;
        checks++; if (PC_IFID_in !== 32'h0) begin errors++; $display("FAIL async_reset: got %h expected %h", PC_IFID_in, 32'h0); end
        @(negedge clk); rst_n = 1;
        tick();
        checks++; if (PC_IFID_in !== 32'h4) begin errors++; $display("FAIL reseq_4: got %h expected %h", PC_IFID_in, 32'h4); end
        tick();
        checks++; if (PC_IFID_in !== 32'h8) begin errors++; $display("FAIL reseq_8: got %h expected %h", PC_IFID_in, 32'h8); end
    endtask

    task automatic test_stall();
        PC_enable = 0;
        takeBranch = 1;
        PC_IFID_IDEX = 32'h8;
        branch_PC = 32'h200;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (PC_IFID_in !== 32'h8) begin errors++; $display("FAIL stall_hold%0d: got %h expected %h", i, PC_IFID_in, 32'h8); end
        end
        clear_in();
        instruction_IFID_in = 32'h63;
        tick();
        checks++; if (PC_IFID_in !== 32'hC) begin errors++; $display("FAIL stall_no_write: got %h expected %h", PC_IFID_in, 32'hC); end
    endtask

    task automatic test_alloc();
        instruction_IFID_in = 32'h13;
        takeBranch = 1;
        PC_IFID_IDEX = 32'h10;
        branch_PC = 32'h40;
        tick();
        checks++; if (PC_IFID_in !== 32'h10) begin errors++; $display("FAIL alloc_seq: got %h expected %h", PC_IFID_in, 32'h10); end
        takeBranch = 0;
        instruction_IFID_in = 32'h63;
        tick();
        checks++; if (PC_IFID_in !== (BTB ? 32'h40 : 32'h14)) begin errors++; $display("FAIL alloc_predict: got %h expected %h", PC_IFID_in, BTB ? 32'h40 : 32'h14); end
    endtask

    task automatic test_predecode();
        go_to(32'h10);
        instruction_IFID_in = 32'h13;
        tick();
        checks++; if (PC_IFID_in !== 32'h14) begin errors++; $display("FAIL predecode_addi: got %h expected %h", PC_IFID_in, 32'h14); end
        go_to(32'h10);
        instruction_IFID_in = 32'h67;
        tick();
        checks++; if (PC_IFID_in !== 32'h14) begin errors++; $display("FAIL predecode_jalr: got %h expected %h", PC_IFID_in, 32'h14); end
        go_to(32'h10);
        instruction_IFID_in = 32'h6F;
        tick();
        checks++; if (PC_IFID_in !== (BTB ? 32'h40 : 32'h14)) begin errors++; $display("FAIL predecode_jal: got %h expected %h", PC_IFID_in, BTB ? 32'h40 : 32'h14); end
    endtask

    task automatic test_mispredict_nt();
        incorrect_b_prediction = 1;
        takeBranch = 0;
        PC_IFID_IDEX = 32'h10;
        PC_plus4_IFID_out = 32'h14;
        tick();
        checks++; if (PC_IFID_in !== 32'h14) begin errors++; $display("FAIL mispredict_nt_redirect: got %h expected %h", PC_IFID_in, 32'h14); end
        go_to(32'h10);
        instruction_IFID_in = 32'h63;
        tick();
        checks++; if (PC_IFID_in !== 32'h14) begin errors++; $display("FAIL mispredict_nt_weak: got %h expected %h", PC_IFID_in, 32'h14); end
    endtask

    task automatic test_saturation();
        instruction_IFID_in = 32'h13;
        incorrect_b_prediction = 1;
        PC_IFID_IDEX = 32'h10;
        PC_plus4_IFID_out = 32'h10;
        tick();
        tick();
        incorrect_b_prediction = 0;
        instruction_IFID_in = 32'h63;
        tick();
        checks++; if (PC_IFID_in !== 32'h14) begin errors++; $display("FAIL sat_low: got %h expected %h", PC_IFID_in, 32'h14); end
        instruction_IFID_in = 32'h13;
        takeBranch = 1;
        branch_PC = 32'h44;
        for (int i = 0; i < 4; i++) tick();
        takeBranch = 0;
        incorrect_b_prediction = 1;
        tick();
        incorrect_b_prediction = 0;
        instruction_IFID_in = 32'h6F;
        tick();
        checks++; if (PC_IFID_in !== (BTB ? 32'h44 : 32'h14)) begin errors++; $display("FAIL sat_high: got %h expected %h", PC_IFID_in, BTB ? 32'h44 : 32'h14); end
    endtask

    task automatic test_mispredict_taken();
        go_to(32'h10);
        instruction_IFID_in = 32'h63;
        incorrect_b_prediction = 1;
        takeBranch = 1;
        branch_PC = 32'h100;
        PC_IFID_IDEX = 32'h200;
        tick();
        checks++; if (PC_IFID_in !== 32'h100) begin errors++; $display("FAIL mispredict_taken: got %h expected %h", PC_IFID_in, 32'h100); end
    endtask

    task automatic test_reset_redirect();
        incorrect_b_prediction = 1;
        takeBranch = 1;
        branch_PC = 32'h300;
        #2 rst_n = 0;
        #1;
        checks++; if (PC_IFID_in !== 32'h0) begin errors++; $display("FAIL reset_redirect: got %h expected %h", PC_IFID_in, 32'h0); end
        tick();
        checks++; if (PC_IFID_in !== 32'h0) begin errors++; $display("FAIL reset_over_edge: got %h expected %h", PC_IFID_in, 32'h0); end
        clear_in();
        @(negedge clk); rst_n = 1; #1;
        checks++; if (PC_IFID_in !== 32'h0) begin errors++; $display("FAIL reset_release: got %h expected %h", PC_IFID_in, 32'h0); end
        go_to(32'h10);
        instruction_IFID_in = 32'h63;
        tick();
        checks++; if (PC_IFID_in !== 32'h14) begin errors++; $display("FAIL reset_clears_btb: got %h expected %h", PC_IFID_in, 32'h14); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_alloc();
        test_predecode();
        test_mispredict_nt();
        test_saturation();
        test_mispredict_taken();
        test_reset_redirect();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
